// File: rtl/line_buff_ctrl.sv
// Sequencer for a 4-deep line-buffer bank feeding a 3-row window: shared column
// address, one-hot write strobes, rotating write target and window row mapping.
module line_buff_ctrl #(
    parameter int LINE_WIDTH = 1600,
    parameter int ADDR_W     = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic              h_sync,
    input  logic              v_sync,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        write_enable,
    output logic [1:0]        wr_sel,
    output logic [1:0]        rd_top,
    output logic [1:0]        rd_mid,
    output logic [1:0]        rd_bot,
    output logic              window_valid,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_WIDTH - 1);

    state_t     state;
    logic [1:0] lines_done;
    logic       line_full;
    logic       line_has_data;
    logic       accept;
    logic       line_end;

    assign accept = pix_valid && !v_sync && !line_full;
    // A pixel arriving with h_sync still marks the line as non-empty.
    assign line_end = h_sync && !v_sync && (line_has_data || accept);

    assign write_enable = accept ? (4'b0001 << wr_sel) : 4'b0000;
    assign window_valid = accept && (state == RUN);

    assign rd_top = wr_sel + 2'd1;
    assign rd_mid = wr_sel + 2'd2;
    assign rd_bot = wr_sel + 2'd3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            address       <= '0;
            wr_sel        <= '0;
            lines_done    <= '0;
            line_full     <= 1'b0;
            line_has_data <= 1'b0;
            overflow      <= 1'b0;
        end else if (v_sync) begin
            state         <= IDLE;
            address       <= '0;
            wr_sel        <= '0;
            lines_done    <= '0;
            line_full     <= 1'b0;
            line_has_data <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (pix_valid && line_full)
                overflow <= 1'b1;

            if (line_end) begin
                address       <= '0;
                wr_sel        <= wr_sel + 2'd1;
                line_full     <= 1'b0;
                line_has_data <= 1'b0;
                if (lines_done != 2'd3)
                    lines_done <= lines_done + 2'd1;
            end else if (accept) begin
                line_has_data <= 1'b1;
                // Last column holds the address so the next pixel is caught as overflow.
                if (address == LAST_COL)
                    line_full <= 1'b1;
                else
                    address <= address + 1'b1;
            end

            case (state)
                IDLE:    if (accept) state <= FILL;
                FILL:    if (line_end && lines_done == 2'd2) state <= RUN;
                RUN:     state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_buff_ctrl.sv
// Scoreboard bench for line_buff_ctrl at LINE_WIDTH=8: directed stimulus pushes
// expected writes; a negedge monitor pops and compares each presented write.
module tb_line_buff_ctrl;

    localparam int LW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_valid;
    logic          h_sync;
    logic          v_sync;
    logic [AW-1:0] address;
    logic [3:0]    write_enable;
    logic [1:0]    wr_sel;
    logic [1:0]    rd_top;
    logic [1:0]    rd_mid;
    logic [1:0]    rd_bot;
    logic          window_valid;
    logic          overflow;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    we;
        logic          wv;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    line_buff_ctrl #(.LINE_WIDTH(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .h_sync(h_sync), .v_sync(v_sync),
        .address(address), .write_enable(write_enable), .wr_sel(wr_sel),
        .rd_top(rd_top), .rd_mid(rd_mid), .rd_bot(rd_bot),
        .window_valid(window_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int n, input logic [3:0] we, input logic wv, input bit hs_last);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            h_sync    = hs_last && (i == n - 1);
            exp_q.push_back('{addr: AW'(i), we: we, wv: wv});
            tick();
        end
        pix_valid = 1'b0;
        h_sync    = 1'b0;
    endtask

    task automatic pulse_h();
        h_sync = 1'b1;
        tick();
        h_sync = 1'b0;
    endtask

    task automatic pulse_v();
        v_sync = 1'b1;
        tick();
        v_sync = 1'b0;
    endtask

    task automatic chk_rd(input string name, input int sel, input int t, input int m, input int b);
        chk({name, " wr_sel"}, int'(wr_sel), sel);
        chk({name, " rd_top"}, int'(rd_top), t);
        chk({name, " rd_mid"}, int'(rd_mid), m);
        chk({name, " rd_bot"}, int'(rd_bot), b);
    endtask

    // Monitor: every presented write must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && write_enable != 4'b0000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected write_enable", int'(write_enable), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb address", int'(address), int'(e.addr));
                chk("sb write_enable", int'(write_enable), int'(e.we));
                chk("sb window_valid", int'(window_valid), int'(e.wv));
            end
        end
    end

    initial begin
        rst = 1'b1; pix_valid = 1'b0; h_sync = 1'b0; v_sync = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("post-reset address", int'(address), 0);
        chk("post-reset overflow", int'(overflow), 0);
        chk_rd("post-reset", 0, 1, 2, 3);

        // Build some state, then reset asynchronously mid-cycle.
        send_line(3, 4'b0001, 1'b0, 1'b0);
        pulse_h();
        send_line(2, 4'b0010, 1'b0, 1'b0);
        chk("pre-rst wr_sel", int'(wr_sel), 1);
        chk("pre-rst address", int'(address), 2);
        #2 rst = 1'b1;
        #1;
        chk("async rst address", int'(address), 0);
        chk("async rst write_enable", int'(write_enable), 0);
        chk("async rst window_valid", int'(window_valid), 0);
        chk_rd("async rst", 0, 1, 2, 3);
        tick();
        rst = 1'b0;
        tick();

        // Fill three lines.
        pulse_v();
        send_line(8, 4'b0001, 1'b0, 1'b0); pulse_h();
        send_line(8, 4'b0010, 1'b0, 1'b0); pulse_h();
        send_line(8, 4'b0100, 1'b0, 1'b0); pulse_h();
        chk_rd("after fill", 3, 0, 1, 2);

        // Run and wrap.
        send_line(8, 4'b1000, 1'b1, 1'b0); pulse_h();
        send_line(8, 4'b0001, 1'b1, 1'b0); pulse_h();
        chk_rd("after wrap", 1, 2, 3, 0);

        // Overflow: 10 pixels, only 8 written.
        send_line(8, 4'b0010, 1'b1, 1'b0);
        chk("full address", int'(address), 7);
        chk("full overflow", int'(overflow), 0);
        pix_valid = 1'b1;
        #1 chk("9th pixel write_enable", int'(write_enable), 0);
        tick();
        chk("ovf address", int'(address), 7);
        chk("ovf overflow", int'(overflow), 1);
        tick();
        pix_valid = 1'b0;
        pulse_h();
        chk("ovf sticky", int'(overflow), 1);
        chk("ovf h_sync address", int'(address), 0);
        chk("ovf h_sync wr_sel", int'(wr_sel), 2);
        pulse_v();
        chk("v_sync clears overflow", int'(overflow), 0);
        chk("v_sync clears wr_sel", int'(wr_sel), 0);

        // Back-to-back h_sync: second one ignored.
        send_line(8, 4'b0001, 1'b0, 1'b0);
        pulse_h();
        pulse_h();
        chk("back-to-back h_sync wr_sel", int'(wr_sel), 1);

        // h_sync together with the 8th pixel.
        send_line(8, 4'b0010, 1'b0, 1'b1);
        chk("hs+pix address", int'(address), 0);
        chk("hs+pix wr_sel", int'(wr_sel), 2);
        send_line(8, 4'b0100, 1'b0, 1'b0); pulse_h();
        send_line(2, 4'b1000, 1'b1, 1'b0);

        // Mid-frame v_sync with pixel present: no write, back to IDLE.
        v_sync = 1'b1; pix_valid = 1'b1;
        #1;
        chk("v_sync write_enable", int'(write_enable), 0);
        chk("v_sync window_valid", int'(window_valid), 0);
        tick();
        v_sync = 1'b0; pix_valid = 1'b0;
        chk("mid v_sync address", int'(address), 0);
        chk("mid v_sync wr_sel", int'(wr_sel), 0);
        send_line(8, 4'b0001, 1'b0, 1'b0); pulse_h();
        send_line(8, 4'b0010, 1'b0, 1'b0); pulse_h();
        send_line(8, 4'b0100, 1'b0, 1'b0); pulse_h();
        send_line(3, 4'b1000, 1'b1, 1'b0);
        tick();

        chk("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_buff_ctrl.md
# line_buff_ctrl

Sequencing controller for a bank of four `line_buff` instances that feed a 3-row sliding-window filter stage. It generates the shared pixel address and the one-hot per-buffer write enables. It rotates the write target on every `h_sync`, reports which three buffers hold the top, middle and bottom window rows, and flags when the window is valid. The block sits between the pixel input stream and the line-buffer bank plus window/kernel stage.

## Interface
- `LINE_WIDTH`, 1600: pixels per line; legal addresses are 0..LINE_WIDTH-1.
- `ADDR_W`, 11: address width; must satisfy 2^ADDR_W >= LINE_WIDTH.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pix_valid` in 1: one input pixel presented this cycle.
- `h_sync` in 1: single-cycle end-of-line pulse.
- `v_sync` in 1: single-cycle start-of-frame pulse.
- `address` out ADDR_W: registered column address, shared by all four buffers.
- `write_enable` out 4: combinational one-hot write strobe, bit i drives buffer i.
- `wr_sel` out 2: registered index of the buffer being written.
- `rd_top` out 2: buffer index holding the oldest window row.
- `rd_mid` out 2: buffer index holding the middle window row.
- `rd_bot` out 2: buffer index holding the newest completed row.
- `window_valid` out 1: combinational; window column at `address` is valid this cycle.
- `overflow` out 1: sticky; a line exceeded LINE_WIDTH pixels.

## Operation
- **State machine.** States are IDLE, FILL and RUN.
  - IDLE → FILL on the first accepted pixel.
  - FILL → RUN on the `h_sync` that completes the 3rd line (`lines_done` reaches 3).
  - RUN stays in RUN until `v_sync`.
  - `v_sync` from any state → IDLE.
- **Accepted pixel.** A pixel is accepted when `pix_valid` is high, `v_sync` is low and `line_full` is low.
  - `write_enable` = (1 << `wr_sel`) when a pixel is accepted, else 0.
  - `address` increments by 1 after each accepted pixel.
  - When the accepted pixel sits at LINE_WIDTH-1, `address` holds and `line_full` is set.
- **Overflow.** `pix_valid` while `line_full` is set: no write, `address` holds, `overflow` is set. `overflow` clears only on `rst` or `v_sync`.
- **Line end.** `h_sync` when `line_has_data` is set:
  - `address` ← 0.
  - `wr_sel` ← `wr_sel`+1 mod 4.
  - `lines_done` ← min(`lines_done`+1, 3).
  - `line_full` and `line_has_data` clear.
- **Empty line.** `h_sync` with no pixel accepted since the last line boundary is ignored: no rotation, no count change.
- **Read mapping.** `rd_top` = `wr_sel`+1, `rd_mid` = `wr_sel`+2, `rd_bot` = `wr_sel`+3, all mod 4 and combinational from `wr_sel`.
- **Window valid.** `window_valid` = accepted pixel AND state == RUN.
- **Frame start.** `v_sync` (highest priority) clears `address`, `wr_sel`, `lines_done`, `line_full`, `line_has_data` and `overflow`. No write occurs in a `v_sync` cycle even if `pix_valid` is high.

## Timing
- **Reset values.** `address`=0, `wr_sel`=0, `write_enable`=0, `rd_top`=1, `rd_mid`=2, `rd_bot`=3, `window_valid`=0, `overflow`=0, state IDLE, `lines_done`=0.
- **Write alignment.** `write_enable` and `address` are valid together in the pixel's cycle. The buffer writes on the closing rising edge; `address` advances on that same edge.
- **Read alignment.** Buffer reads capture `address` on the mid-cycle falling edge. The read-buffer `data_out` for column `address` is therefore stable at the rising edge that ends the `window_valid` cycle; the consumer samples there. Zero added latency.
- **h_sync with pix_valid.** When both are high in the same cycle, the pixel is written to the current `wr_sel`/`address` first. The rotation takes effect on that edge, so the next cycle shows `address`=0 and the new `wr_sel`. Such a pixel counts toward `line_has_data`.
- **Reset mid-line.** `rst` mid-line returns all state to reset values immediately, with no edge required. Partially filled buffers are discarded by restarting FILL.
- **Accept rate.** One pixel per cycle sustained; no back-pressure.

## Test plan
Bench uses LINE_WIDTH=8, ADDR_W=3.

- **Reset.** Assert `rst` asynchronously mid-cycle → all outputs take reset values before the next edge; `rd_top`/`rd_mid`/`rd_bot` = 1/2/3.
- **Fill sequence.** `v_sync`, then three lines of 8 pixels each followed by `h_sync` → `write_enable` = 0001, 0010, 0100 per line; `window_valid` = 0 throughout. After the 3rd `h_sync`: `wr_sel`=3, `rd_top`/`rd_mid`/`rd_bot` = 0/1/2.
- **Run and wrap.** 4th and 5th lines of 8 pixels → `window_valid` high for all 8 pixels of each line. `write_enable` = 1000, then 0001. After the 5th `h_sync`: `wr_sel`=1, `rd_top`/`rd_mid`/`rd_bot` = 2/3/0.
- **Overflow.** A line of 10 pixels → writes at addresses 0..7 only, `address` holds at 7. `overflow` rises on the 9th pixel and stays high through `h_sync`; the next `v_sync` clears it.
- **Boundary events.**
  - Back-to-back `h_sync` → the second is ignored (`wr_sel` unchanged).
  - `h_sync` in the same cycle as the 8th pixel → that pixel is written at address 7, then `address`=0.
- **Mid-frame v_sync.** `v_sync` during RUN with `pix_valid` high → `write_enable`=0 that cycle, state IDLE. `window_valid` stays 0 until three new lines complete.
